// File: rtl/image_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_pkg
//  Purpose  : Shared state encoding and default widths for the image stream
//             transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
package image_stream_pkg;

  // Default widths: pixel, column counter, row counter, blanking counter
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WIDTH_W  = 11;
  localparam int DEF_HEIGHT_W = 10;
  localparam int DEF_HBLANK_W = 8;

  // Transmitter states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LINE  = 3'd1,
    S_BLANK = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/image_stream_tpg.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_tpg
//  Purpose  : Diagonal-ramp test pattern: pixel = (x + y) mod 2^DATA_W.
//             Purely combinational; the caller registers the result.
//  Revision : 1.0 - initial release
// ============================================================================
module image_stream_tpg
  import image_stream_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WIDTH_W  = DEF_WIDTH_W,
  parameter int HEIGHT_W = DEF_HEIGHT_W
) (
  input  logic [WIDTH_W-1:0]  i_x,
  input  logic [HEIGHT_W-1:0] i_y,
  output logic [DATA_W-1:0]   o_pixel
);

  // Casting both operands to the pixel width makes the modulo implicit
  assign o_pixel = DATA_W'(i_x) + DATA_W'(i_y);

endmodule
`default_nettype wire

// File: rtl/image_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : image_stream_tx
//  Purpose  : Re-times an upstream ready/valid pixel stream into a raster of
//             img_width x img_height with programmable horizontal blanking,
//             frame/line flags, and one trailing zero flush line per frame.
//  Options  : IMAGE_STREAM_TX_TPG_EN adds input tpg_en and an internal
//             (x+y) test pattern source used in place of the upstream stream.
//  Revision : 1.0 - initial release
// ============================================================================
module image_stream_tx
  import image_stream_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WIDTH_W  = DEF_WIDTH_W,
  parameter int HEIGHT_W = DEF_HEIGHT_W,
  parameter int HBLANK_W = DEF_HBLANK_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH_W-1:0]  img_width,
  input  logic [HEIGHT_W-1:0] img_height,
  input  logic [HBLANK_W-1:0] hblank,
  input  logic                start,
`ifdef IMAGE_STREAM_TX_TPG_EN
  input  logic                tpg_en,
`endif
  output logic                busy,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  output logic                valid_o,
  output logic [DATA_W-1:0]   img_data_o,
  output logic                sof_o,
  output logic                eol_o,
  output logic                eof_o,
  output logic                frame_done
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_LINE  = S_LINE;
  localparam logic [2:0] ST_BLANK = S_BLANK;
  localparam logic [2:0] ST_FLUSH = S_FLUSH;
  localparam logic [2:0] ST_DONE  = S_DONE;

  logic [2:0]          r_state;
  logic [WIDTH_W-1:0]  r_width;
  logic [HEIGHT_W-1:0] r_height;
  logic [HBLANK_W-1:0] r_hblank;
  logic [WIDTH_W-1:0]  r_x;
  logic [HEIGHT_W-1:0] r_y;
  logic [HBLANK_W-1:0] r_bcnt;

  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_sof;
  logic                r_eol;
  logic                r_eof;
  logic                r_done;

  logic                w_start_ok;
  logic                w_emit;     // a line pixel is produced on this edge
  logic [DATA_W-1:0]   w_pix;
  logic                w_last_x;
  logic                w_last_y;
  logic                w_last_b;

  assign w_start_ok = start && (img_width != '0) && (img_height != '0);
  assign w_last_x   = (r_x == r_width - 1'b1);
  assign w_last_y   = (r_y == r_height - 1'b1);
  assign w_last_b   = (r_bcnt == r_hblank - 1'b1);

`ifdef IMAGE_STREAM_TX_TPG_EN
  logic              r_tpg;
  logic [DATA_W-1:0] w_tpg_pix;

  image_stream_tpg #(
    .DATA_W   (DATA_W),
    .WIDTH_W  (WIDTH_W),
    .HEIGHT_W (HEIGHT_W)
  ) u_tpg (
    .i_x     (r_x),
    .i_y     (r_y),
    .o_pixel (w_tpg_pix)
  );

  // Pattern mode runs the line at one pixel per cycle and shuts the upstream out
  assign w_emit  = (r_state == ST_LINE) && (r_tpg || s_valid);
  assign w_pix   = r_tpg ? w_tpg_pix : s_data;
  assign s_ready = (r_state == ST_LINE) && !r_tpg;
`else
  assign w_emit  = (r_state == ST_LINE) && s_valid;
  assign w_pix   = s_data;
  assign s_ready = (r_state == ST_LINE);
`endif

  // busy and s_ready decode the state register only, so no input reaches them
  assign busy       = (r_state != ST_IDLE);
  assign valid_o    = r_valid;
  assign img_data_o = r_data;
  assign sof_o      = r_sof;
  assign eol_o      = r_eol;
  assign eof_o      = r_eof;
  assign frame_done = r_done;

  // Frame sequencing: configuration latch, raster counters and state transitions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_width  <= '0;
      r_height <= '0;
      r_hblank <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_bcnt   <= '0;
`ifdef IMAGE_STREAM_TX_TPG_EN
      r_tpg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_width  <= img_width;
            r_height <= img_height;
            r_hblank <= hblank;
`ifdef IMAGE_STREAM_TX_TPG_EN
            r_tpg    <= tpg_en;
`endif
            r_x      <= '0;
            r_y      <= '0;
            r_bcnt   <= '0;
            r_state  <= ST_LINE;
          end
        end
        ST_LINE: begin
          if (w_emit) begin
            if (w_last_x) begin
              r_x <= '0;
              if (r_hblank != '0) begin
                r_bcnt  <= '0;
                r_state <= ST_BLANK;
              end else if (w_last_y) begin
                r_state <= ST_FLUSH;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (w_last_b) begin
            r_bcnt <= '0;
            if (w_last_y) begin
              r_state <= ST_FLUSH;
            end else begin
              r_y     <= r_y + 1'b1;
              r_state <= ST_LINE;
            end
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (w_last_x) begin
            r_x     <= '0;
            r_state <= ST_DONE;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: pixel strobe, data and boundary flags, one edge after acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_emit || (r_state == ST_FLUSH);
      if (w_emit) begin
        r_data <= w_pix;
      end else if (r_state == ST_FLUSH) begin
        r_data <= '0;
      end
      r_sof  <= w_emit && (r_x == '0) && (r_y == '0);
      r_eol  <= w_emit && w_last_x;
      r_eof  <= (r_state == ST_FLUSH) && w_last_x;
      r_done <= (r_state == ST_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_stream_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_image_stream_tx
//  Purpose  : Scoreboard bench for image_stream_tx. Each frame's expected
//             output stream (pixels with flags, zero flush line, frame_done)
//             is queued when the frame is requested; a negedge monitor pops
//             and compares every output event.
//  Options  : IMAGE_STREAM_TX_TPG_EN enables the test-pattern frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_image_stream_tx;

  localparam int DW = 8;
  localparam int WW = 11;
  localparam int HW = 10;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [WW-1:0] img_width = '0;
  logic [HW-1:0] img_height = '0;
  logic [BW-1:0] hblank = '0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
`ifdef IMAGE_STREAM_TX_TPG_EN
  logic          tpg_en = 1'b0;
`endif
  logic          busy, s_ready, valid_o, sof_o, eol_o, eof_o, frame_done;
  logic [DW-1:0] img_data_o;

  image_stream_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .img_width  (img_width),
    .img_height (img_height),
    .hblank     (hblank),
    .start      (start),
`ifdef IMAGE_STREAM_TX_TPG_EN
    .tpg_en     (tpg_en),
`endif
    .busy       (busy),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .valid_o    (valid_o),
    .img_data_o (img_data_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o),
    .eof_o      (eof_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            done;
    logic [DW-1:0] data;
    bit            sof;
    bit            eol;
    bit            eof;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor state: event counters only ever written here
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   r0_cnt   = 0;
  int   r1_cnt   = 0;
  int   gap_cnt  = 0;
  int   pend     = 0;
  bit   seen_v   = 0;
  exp_t m_e;

  // Output monitor: pops the scoreboard on every pixel strobe and frame_done
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy && !s_ready) r0_cnt++;
      if (s_ready) r1_cnt++;
      if (!busy) begin
        seen_v = 0;
        pend   = 0;
      end else if (valid_o) begin
        gap_cnt += pend;
        pend   = 0;
        seen_v = 1;
      end else if (seen_v) begin
        pend++;
      end

      if (valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_pixel", 64'(img_data_o), 64'hDEAD);
        end else begin
          m_e = q.pop_front();
          chk("pixel{done,data,sof,eol,eof}",
              64'({1'b0, img_data_o, sof_o, eol_o, eof_o}),
              64'({m_e.done, m_e.data, m_e.sof, m_e.eol, m_e.eof}));
        end
      end
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("unexpected_frame_done", 64'(1), 64'(0));
        end else begin
          m_e = q.pop_front();
          chk("frame_done_slot", 64'(1), 64'(m_e.done));
        end
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Runs one frame. mode: 0 continuous, 1 toggling, 2 random s_valid.
  task automatic run_frame(input int w, input int h, input int b, input int mode,
                           input bit seq, input bit tpg, input int abort_at,
                           input bit overlap);
    logic [DW-1:0] pix[$];
    exp_t          e;
    int            idx, guard, first_acc, d0, r0s, r1s, g0s;
    bit            v, rdy;

    pix.delete();
    for (int k = 0; k < w * h; k++) begin
      if (tpg)      pix.push_back(DW'((k % w) + (k / w)));
      else if (seq) pix.push_back(DW'(k + 1));
      else          pix.push_back(DW'($urandom));
    end

    // Expected stream: raster pixels, a zero flush line, then frame_done
    for (int k = 0; k < w * h; k++) begin
      e.done = 0; e.data = pix[k]; e.sof = (k == 0);
      e.eol = ((k % w) == w - 1); e.eof = 0;
      q.push_back(e);
    end
    for (int k = 0; k < w; k++) begin
      e.done = 0; e.data = '0; e.sof = 0; e.eol = 0; e.eof = (k == w - 1);
      q.push_back(e);
    end
    e.done = 1; e.data = '0; e.sof = 0; e.eol = 0; e.eof = 0;
    q.push_back(e);

    @(posedge clk); #1;
    img_width  = WW'(w);
    img_height = HW'(h);
    hblank     = BW'(b);
`ifdef IMAGE_STREAM_TX_TPG_EN
    tpg_en     = tpg;
`endif
    start      = 1'b1;
    d0 = done_cnt; r0s = r0_cnt; r1s = r1_cnt; g0s = gap_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ready_after_start", 64'({busy, s_ready}), tpg ? 64'(2'b10) : 64'(2'b11));

    idx = 0; guard = 0; first_acc = -1;
    if (tpg) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
    end
    while (idx < w * h && !tpg) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      rdy     = s_ready;
      s_valid = v;
      s_data  = v ? pix[idx] : DW'($urandom);
      if (overlap && idx == w) begin
        start      = 1'b1;
        img_width  = WW'(w + 3);
        img_height = HW'(h + 1);
        hblank     = BW'(b + 2);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (v && rdy) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      guard++;
      if (abort_at > 0 && idx == abort_at) break;
      if (guard > 3000) begin
        chk("accept_timeout", 64'(idx), 64'(w * h));
        break;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;

    if (abort_at > 0) begin
      #2 reset_n = 1'b0;
      #1;
      chk("outputs_zero_in_reset",
          64'({s_ready, busy, valid_o, img_data_o, sof_o, eol_o, eof_o, frame_done}), 64'(0));
      q.delete();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("no_done_after_abort", 64'(done_cnt - d0), 64'(0));
      chk("idle_after_abort", 64'(busy), 64'(0));
      return;
    end

    guard = 0;
    while (done_cnt == d0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("single_frame_done", 64'(done_cnt - d0), 64'(1));
    chk("busy_low_after_frame", 64'(busy), 64'(0));
    chk("ready_low_busy_cycles", 64'(r0_cnt - r0s), 64'(h * b + w + 1 + (tpg ? h * w : 0)));
    if (tpg) chk("tpg_ready_never", 64'(r1_cnt - r1s), 64'(0));
    if (mode == 0 && !tpg) begin
      chk("frame_cycles", 64'(done_cyc + 1 - first_acc), 64'(h * (w + b) + w + 1));
      chk("valid_gap_cycles", 64'(gap_cnt - g0s), 64'(h * b));
    end
    chk("queue_drained", 64'(q.size()), 64'(0));
  endtask

  task automatic bad_start(input int w, input int h);
    @(posedge clk); #1;
    img_width = WW'(w); img_height = HW'(h); hblank = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_illegal_start", 64'({busy, s_ready}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("still_idle_after_illegal_start", 64'(busy), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({s_ready, busy, valid_o, img_data_o, sof_o, eol_o, eof_o, frame_done}), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'({busy, s_ready, valid_o}), 64'(0));

    run_frame(4, 3, 0, 0, 1, 0, 0, 0);   // basic, data 1..12
    run_frame(4, 2, 3, 0, 0, 0, 0, 0);   // blanking
    run_frame(4, 2, 1, 1, 0, 0, 0, 0);   // toggling upstream with blanking
    run_frame(4, 2, 0, 1, 0, 0, 0, 0);   // toggling upstream, no blanking
    bad_start(0, 3);
    bad_start(4, 0);
    run_frame(5, 3, 2, 2, 0, 0, 0, 1);   // second start and config change mid-frame
    run_frame(4, 3, 0, 0, 0, 0, 6, 0);   // reset after pixel 6
    run_frame(4, 3, 0, 0, 1, 0, 0, 0);   // clean frame after reset
    run_frame(1, 1, 0, 0, 0, 0, 0, 0);   // smallest frame
    run_frame(1, 2, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(1, 9), $urandom_range(1, 5), $urandom_range(0, 4),
                $urandom_range(0, 2), 0, 0, 0, 0);
    end
`ifdef IMAGE_STREAM_TX_TPG_EN
    run_frame(3, 2, 0, 0, 0, 1, 0, 0);   // 0,1,2,1,2,3 then 0,0,0
    run_frame(3, 2, 2, 0, 0, 1, 0, 0);
    run_frame(4, 2, 1, 2, 0, 0, 0, 0);   // back to upstream source
`endif

    chk("final_queue_empty", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout got=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
